edge_debouncer: RTL

//  Multi-channel symmetric debouncer for pre-synchronized button/switch inputs.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_channel.sv | 136 +++++++++++++
 rtl/edge_debouncer.sv | 62 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the input-debounce blocks.
package debounce_pkg;

    localparam logic TICK_ACTIVE   = 1'b1;
    localparam logic STROBE_ACTIVE = 1'b1;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    // $clog2 clamped to at least one bit so degenerate counters still exist
    function automatic int clog2_min1(input int value);
        return (value > 32'sd2) ? $clog2(value) : 32'sd1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: mismatch counter, level register and edge strobes.
// Auto-repeat strobes are built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   PULSE_COUNT_MAX = 150,
    parameter logic RESET_VALUE     = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int   HOLD_TICKS      = 500,
    parameter int   REPEAT_TICKS    = 100
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_glitchy,
    output logic o_debounced,
    output logic o_rise_pulse,
    output logic o_fall_pulse,
    output logic o_repeat_pulse
);

    localparam int              CW       = clog2_min1(PULSE_COUNT_MAX + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(PULSE_COUNT_MAX - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_mismatch;
    logic          w_flip;
    edge_e         w_edge;

    assign w_mismatch = i_glitchy ^ r_level;

    // Mismatch counter: any agreeing cycle clears, the last tick flips the level
    always_comb begin
        w_count_next = r_count;
        w_flip       = 1'b0;
        if (!w_mismatch) begin
            w_count_next = {CW{1'b0}};
        end else if (i_tick == TICK_ACTIVE) begin
            if (r_count == CNT_LAST) begin
                w_count_next = {CW{1'b0}};
                w_flip       = 1'b1;
            end else begin
                w_count_next = r_count + CW'(1'b1);
            end
        end else begin
            w_count_next = r_count;
        end
    end

    // Direction of the pending flip
    always_comb begin
        w_edge = EDGE_NONE;
        if (w_flip) begin
            w_edge = r_level ? EDGE_FALL : EDGE_RISE;
        end else begin
            w_edge = EDGE_NONE;
        end
    end

    // Level, counter and edge strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CW{1'b0}};
            r_level <= RESET_VALUE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_level <= r_level ^ w_flip;
            r_rise  <= (w_edge == EDGE_RISE) ? STROBE_ACTIVE : 1'b0;
            r_fall  <= (w_edge == EDGE_FALL) ? STROBE_ACTIVE : 1'b0;
        end
    end

    assign o_debounced  = r_level;
    assign o_rise_pulse = r_rise;
    assign o_fall_pulse = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int            HW        = clog2_min1((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);

    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_next;
    logic          r_repeating;
    logic          w_repeating_next;
    logic          w_repeat_fire;
    logic          r_repeat;

    // Hold counter: first period is HOLD_TICKS, then REPEAT_TICKS; any flip restarts it
    always_comb begin
        w_hold_next      = r_hold;
        w_repeating_next = r_repeating;
        w_repeat_fire    = 1'b0;
        if (!r_level || w_flip) begin
            w_hold_next      = {HW{1'b0}};
            w_repeating_next = 1'b0;
        end else if (i_tick == TICK_ACTIVE) begin
            if (r_hold == (r_repeating ? REP_LAST : HOLD_LAST)) begin
                w_hold_next      = {HW{1'b0}};
                w_repeating_next = 1'b1;
                w_repeat_fire    = 1'b1;
            end else begin
                w_hold_next = r_hold + HW'(1'b1);
            end
        end else begin
            w_hold_next = r_hold;
        end
    end

    // Repeat counter and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= {HW{1'b0}};
            r_repeating <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_hold      <= w_hold_next;
            r_repeating <= w_repeating_next;
            r_repeat    <= w_repeat_fire ? STROBE_ACTIVE : 1'b0;
        end
    end

    assign o_repeat_pulse = r_repeat;
`else
    assign o_repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/edge_debouncer.sv
// Multi-channel debouncer top: shared sample prescaler plus one channel per bit.
// Define DEBOUNCE_REPEAT_EN to build the auto-repeat strobes.
module edge_debouncer
    import debounce_pkg::*;
#(
    parameter int               WIDTH            = 1,
    parameter int               SAMPLE_COUNT_MAX = 25000,
    parameter int               PULSE_COUNT_MAX  = 150,
    parameter logic [WIDTH-1:0] RESET_VALUE      = {WIDTH{1'b0}},
    parameter int               HOLD_TICKS       = 500,
    parameter int               REPEAT_TICKS     = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] repeat_pulse
);

    localparam int            PW         = clog2_min1(SAMPLE_COUNT_MAX);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_COUNT_MAX - 1);

    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PRESC_LAST) ? TICK_ACTIVE : 1'b0;

    // Sample prescaler, wraps after the tick cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= {PW{1'b0}};
        end else if (w_tick == TICK_ACTIVE) begin
            r_presc <= {PW{1'b0}};
        end else begin
            r_presc <= r_presc + PW'(1'b1);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        debounce_channel #(
            .PULSE_COUNT_MAX (PULSE_COUNT_MAX),
            .RESET_VALUE     (RESET_VALUE[gi])
`ifdef DEBOUNCE_REPEAT_EN
            ,
            .HOLD_TICKS      (HOLD_TICKS),
            .REPEAT_TICKS    (REPEAT_TICKS)
`endif
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .i_tick         (w_tick),
            .i_glitchy      (glitchy_signal[gi]),
            .o_debounced    (debounced_signal[gi]),
            .o_rise_pulse   (rise_pulse[gi]),
            .o_fall_pulse   (fall_pulse[gi]),
            .o_repeat_pulse (repeat_pulse[gi])
        );
    end

endmodule
